// File: rtl/mux4_rr_arbiter.sv
// Four-requester round-robin arbiter that steers the granted requester's data onto one shared output.
// Optional per-grant transfer limit enabled by the ARB_TIMEOUT_EN macro.
module mux4_rr_arbiter #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] din0,
    input  logic [WIDTH-1:0] din1,
    input  logic [WIDTH-1:0] din2,
    input  logic [WIDTH-1:0] din3,
    output logic [3:0]       gnt,
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [3:0]       r_gnt, w_gnt_nxt;
    logic [1:0]       r_sel, w_sel_nxt;
    logic [1:0]       r_ptr, w_ptr_nxt;
    logic [1:0]       w_winner;
    logic [1:0]       w_idx;
    logic             w_found;
    logic             w_force_rel;
    logic [WIDTH-1:0] w_mux;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(MAX_HOLD + 1);
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          w_xfer;
    logic          w_at_limit;
    logic          w_others;

    assign w_xfer      = dout_valid & dout_ready;
    assign w_at_limit  = ((r_cnt + CW'(1)) == CW'(MAX_HOLD));
    assign w_others    = |(req & ~r_gnt);
    assign w_force_rel = w_xfer & w_at_limit & w_others;
`else
    logic w_unused;
    assign w_unused    = dout_ready | (MAX_HOLD == 0);
    assign w_force_rel = 1'b0;
`endif

    // Round-robin search: first set request starting at ptr, wrapping modulo 4.
    always_comb begin
        w_winner = r_ptr;
        w_found  = 1'b0;
        w_idx    = r_ptr;
        for (int k = 0; k < 4; k++) begin
            w_idx = r_ptr + 2'(k);
            if (!w_found && req[w_idx]) begin
                w_winner = w_idx;
                w_found  = 1'b1;
            end else begin
                w_found  = w_found;
            end
        end
    end

    // Next-state logic: arbitration in IDLE, release or transfer counting in GRANT.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_sel_nxt   = r_sel;
        w_ptr_nxt   = r_ptr;
`ifdef ARB_TIMEOUT_EN
        w_cnt_nxt   = r_cnt;
`endif
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt = GRANT;
                    w_gnt_nxt   = 4'b0001 << w_winner;
                    w_sel_nxt   = w_winner;
`ifdef ARB_TIMEOUT_EN
                    w_cnt_nxt   = {CW{1'b0}};
`endif
                end else begin
                    w_gnt_nxt   = 4'b0000;
                end
            end
            GRANT: begin
                if (!req[r_sel] || w_force_rel) begin
                    // Pointer moves past the releasing requester so it gets lowest priority next.
                    w_state_nxt = IDLE;
                    w_gnt_nxt   = 4'b0000;
                    w_ptr_nxt   = r_sel + 2'd1;
                end else begin
`ifdef ARB_TIMEOUT_EN
                    if (w_xfer) begin
                        w_cnt_nxt = w_at_limit ? {CW{1'b0}} : (r_cnt + CW'(1));
                    end else begin
                        w_cnt_nxt = r_cnt;
                    end
`else
                    w_state_nxt = GRANT;
`endif
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = 4'b0000;
            end
        endcase
    end

    // State and grant registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_gnt   <= 4'b0000;
            r_sel   <= 2'd0;
            r_ptr   <= 2'd0;
`ifdef ARB_TIMEOUT_EN
            r_cnt   <= {CW{1'b0}};
`endif
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_sel   <= w_sel_nxt;
            r_ptr   <= w_ptr_nxt;
`ifdef ARB_TIMEOUT_EN
            r_cnt   <= w_cnt_nxt;
`endif
        end
    end

    // 4:1 data selection on the registered index.
    always_comb begin
        case (r_sel)
            2'd0:    w_mux = din0;
            2'd1:    w_mux = din1;
            2'd2:    w_mux = din2;
            2'd3:    w_mux = din3;
            default: w_mux = {WIDTH{1'b0}};
        endcase
    end

    assign gnt        = r_gnt;
    assign sel        = r_sel;
    assign busy       = (r_state == GRANT);
    assign dout       = (r_state == GRANT) ? w_mux : {WIDTH{1'b0}};
    assign dout_valid = (r_state == GRANT) & req[r_sel];

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: directed scenarios plus randomized traffic against a behavioural model.
// Timeout scenarios are compiled in when ARB_TIMEOUT_EN is defined.
module tb_mux4_rr_arbiter;

    localparam int W    = 8;
    localparam int MAXH = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req;
    logic [W-1:0] din0, din1, din2, din3;
    logic [3:0]   gnt;
    logic [1:0]   sel;
    logic [W-1:0] dout;
    logic         dout_valid;
    logic         dout_ready;
    logic         busy;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: who holds the bus, where the search starts, transfers so far.
    bit m_busy;
    int m_owner;
    int m_ptr;
    int m_cnt;

    mux4_rr_arbiter #(.WIDTH(W), .MAX_HOLD(MAXH)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .din0(din0), .din1(din1), .din2(din2), .din3(din3),
        .gnt(gnt), .sel(sel), .dout(dout), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] din_of(input int i);
        logic [W-1:0] d [4];
        d[0] = din0; d[1] = din1; d[2] = din2; d[3] = din3;
        return d[i];
    endfunction

    task automatic model_step();
        int others;
        if (!rst_n) begin
            m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0;
        end else if (!m_busy) begin
            for (int k = 0; k < 4; k++) begin
                if (!m_busy && req[(m_ptr + k) % 4]) begin
                    m_busy  = 1;
                    m_owner = (m_ptr + k) % 4;
                    m_cnt   = 0;
                end
            end
        end else if (!req[m_owner]) begin
            m_busy = 0;
            m_ptr  = (m_owner + 1) % 4;
        end else begin
`ifdef ARB_TIMEOUT_EN
            if (dout_ready) begin
                m_cnt++;
                if (m_cnt == MAXH) begin
                    others = int'(req) & ~(1 << m_owner);
                    if (others != 0) begin
                        m_busy = 0;
                        m_ptr  = (m_owner + 1) % 4;
                    end
                    m_cnt = 0;
                end
            end
`else
            others = 0;
`endif
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = 4'b0000;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic compare_model(input string tag);
        chk({tag, "_gnt"},   32'(gnt),        m_busy ? 32'(1 << m_owner) : 32'd0);
        chk({tag, "_sel"},   32'(sel),        32'(m_owner));
        chk({tag, "_busy"},  32'(busy),       32'(m_busy));
        chk({tag, "_dout"},  32'(dout),       m_busy ? 32'(din_of(m_owner)) : 32'd0);
        chk({tag, "_valid"}, 32'(dout_valid), 32'(m_busy && req[m_owner]));
    endtask

    initial begin
        int xfers;
        rst_n = 1'b0; req = 4'b0000; dout_ready = 1'b1;
        din0 = 8'hA5; din1 = 8'h3C; din2 = 8'h5A; din3 = 8'hC3;
        m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0;

        // Reset state, then a single request from requester 0.
        do_reset();
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_valid", 32'(dout_valid), 32'd0);
        req = 4'b0001;
        tick();
        chk("s1_gnt", 32'(gnt), 32'h1);
        chk("s1_sel", 32'(sel), 32'd0);
        chk("s1_dout", 32'(dout), 32'hA5);
        chk("s1_valid", 32'(dout_valid), 32'd1);
        chk("s1_busy", 32'(busy), 32'd1);

        // All requesting; each winner leaves after one transfer: order 0,1,2,3,0 with one bubble.
        do_reset();
        req = 4'b1111;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("rr_sel", 32'(sel), 32'(i % 4));
            chk("rr_gnt", 32'(gnt), 32'(1 << (i % 4)));
            chk("rr_valid", 32'(dout_valid), 32'd1);
            tick();
            req = 4'b1111 & ~(4'b0001 << (i % 4));
            tick();
            chk("rr_bubble", 32'(busy), 32'd0);
            chk("rr_bubble_gnt", 32'(gnt), 32'd0);
            req = 4'b1111;
            tick();
            chk("rr_regrant", 32'(busy), 32'd1);
        end

        // Grant on 2, then 1011: next winners 3, 0, 1.
        do_reset();
        req = 4'b0100;
        tick();
        chk("p_gnt2", 32'(gnt), 32'h4);
        req = 4'b1011;
        tick();
        tick();
        chk("p_gnt3", 32'(gnt), 32'h8);
        req = 4'b0011;
        tick();
        tick();
        chk("p_gnt0", 32'(gnt), 32'h1);
        req = 4'b0010;
        tick();
        tick();
        chk("p_gnt1", 32'(gnt), 32'h2);
        chk("p_sel1", 32'(sel), 32'd1);

        // Reset in the middle of a grant.
        do_reset();
        req = 4'b0100;
        tick();
        chk("mr_pre", 32'(gnt), 32'h4);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mr_gnt", 32'(gnt), 32'd0);
        chk("mr_sel", 32'(sel), 32'd0);
        chk("mr_valid", 32'(dout_valid), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        req = 4'b1111;
        tick();
        chk("mr_first", 32'(gnt), 32'h1);

`ifdef ARB_TIMEOUT_EN
        // Transfer limit with a competitor: exactly MAXH beats, one bubble, then requester 1.
        do_reset();
        req = 4'b0011; dout_ready = 1'b1;
        tick();
        xfers = 0;
        for (int i = 0; i < 20; i++) begin
            if (gnt == 4'b0001 && dout_valid && dout_ready) begin
                xfers++;
                tick();
            end
        end
        chk("to_xfers", 32'(xfers), 32'(MAXH));
        chk("to_bubble", 32'(busy), 32'd0);
        tick();
        chk("to_next", 32'(gnt), 32'h2);

        // Lone requester never loses its grant.
        do_reset();
        req = 4'b0001;
        tick();
        xfers = 0;
        for (int i = 0; i < 10; i++) begin
            if (gnt == 4'b0001 && dout_valid && dout_ready) xfers++;
            tick();
        end
        chk("to_solo_xfers", 32'(xfers), 32'd10);
        chk("to_solo_gnt", 32'(gnt), 32'h1);
`else
        xfers = 0;
`endif

        // Randomized traffic checked against the model every cycle.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            req = 4'($urandom);
            if (m_busy && $urandom_range(0, 9) < 8) req[m_owner] = 1'b1;
            din0 = 8'($urandom); din1 = 8'($urandom);
            din2 = 8'($urandom); din3 = 8'($urandom);
            dout_ready = ($urandom_range(0, 3) != 0);
            rst_n = ($urandom_range(0, 63) != 0);
            @(negedge clk);
            compare_model("rnd");
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mux4_rr_arbiter.md
MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- WIDTH, 8, requester data width
- MAX_HOLD, 16, transfers allowed per grant when ARB_TIMEOUT_EN is defined
REQ-002 Ports SHALL be (name direction width meaning):
- clk input 1 sole clock, rising edge
- rst_n input 1 synchronous active-low reset
- req input 4 per-requester request; bit i = requester i
- din0, din1, din2, din3 input WIDTH requester data
- gnt output 4 one-hot grant, registered
- sel output 2 index of the granted requester, registered
- dout output WIDTH shared data output
- dout_valid output 1 dout holds a valid beat
- dout_ready input 1 downstream accepts a beat
- busy output 1 a grant is active
REQ-003 The block SHALL use one clock; reset SHALL be synchronous and active-low on rst_n.

Function
REQ-004 The state machine SHALL have two states: IDLE and GRANT.
REQ-005 In IDLE with req != 0, the next clock edge SHALL select the first set req bit searching from ptr upward, modulo 4.
- On that edge, gnt SHALL become the one-hot of the winner and sel its index.
- The state SHALL move to GRANT.
REQ-006 In IDLE with req == 0, gnt, sel and ptr SHALL hold, except that gnt SHALL stay 0.
REQ-007 In GRANT, dout SHALL equal din[sel] combinationally (a 4:1 case selection on sel), and dout_valid SHALL equal req[sel].
REQ-008 In IDLE, dout SHALL be 0 and dout_valid SHALL be 0.
REQ-009 A transfer SHALL occur on each edge where dout_valid and dout_ready are both 1.
REQ-010 In GRANT, when req[sel] is 0 at an edge (release):
- gnt SHALL become 0.
- ptr SHALL become sel+1 mod 4.
- The state SHALL return to IDLE.
REQ-011 Each release SHALL leave exactly one IDLE (bubble) cycle before the next grant.
REQ-012 Changes to req bits other than req[sel] during GRANT SHALL have no effect until the next arbitration.
REQ-013 busy SHALL be 1 exactly when the state is GRANT.
REQ-014 gnt SHALL be one-hot or zero at all times.
REQ-015 dout_ready SHALL NOT affect grant or release timing, except via the transfer count (REQ-020).

Reset
REQ-016 While rst_n is 0 at a rising edge, the following SHALL take their reset values irrespective of all other inputs, including mid-GRANT:
- state = IDLE
- gnt = 0, sel = 0, ptr = 0
- transfer count = 0
REQ-017 As a consequence of REQ-008 and REQ-013, dout = 0, dout_valid = 0 and busy = 0 in the cycle after that edge.
REQ-018 After reset, the first arbitration SHALL give priority order 0, 1, 2, 3.

Configuration
REQ-019 The macro ARB_TIMEOUT_EN SHALL control the per-grant transfer limit.
REQ-020 With ARB_TIMEOUT_EN defined, the counter SHALL behave as follows:
- A transfer counter of $clog2(MAX_HOLD+1) bits SHALL clear on entry to GRANT and increment on each transfer.
- When a transfer brings the count to MAX_HOLD and any other req bit is set at that edge, the grant SHALL be force-released as in REQ-010.
- When no other req bit is set at that edge, the counter SHALL clear and the grant SHALL continue.
REQ-021 Without ARB_TIMEOUT_EN, no counter SHALL exist and a grant SHALL be held until req[sel] drops.

Verification
REQ-022 The bench SHALL cover these scenarios:
- Reset then req=4'b0001, din0=8'hA5, dout_ready=1 -> one cycle later gnt=0001, sel=0, dout=A5, dout_valid=1, busy=1.
- req=4'b1111 held, each winner drops req after one transfer -> grant order 0, 1, 2, 3, 0 with one idle cycle between grants.
- Grant held on requester 2, drop req[2] while req=4'b1011 -> next grant goes to 3 (ptr=3), then 0 (ptr=0), then 1 (ptr=1).
- ARB_TIMEOUT_EN, MAX_HOLD=4, req=4'b0011 held, dout_ready=1 -> gnt=0001 for exactly 4 transfers, IDLE for 1 cycle, then gnt=0010.
- ARB_TIMEOUT_EN, MAX_HOLD=4, only req0 held -> grant never released and 10 consecutive transfers occur.
- rst_n=0 for one edge while gnt=0100 -> next cycle gnt=0, sel=0, dout_valid=0, busy=0; req=4'b1111 -> gnt=0001.
